// File: rtl/gpio_serial_cfg_loader_if.sv
// Bus bundle between the GPIO config loader, the config register file and the pad chains.
// The master modport is the loader side; the slave modport is the housekeeping/chain side.
interface gpio_serial_cfg_loader_if #(
  parameter int NUM_PADS = 38,
  parameter int CFG_BITS = 13
);
  localparam int AW = $clog2(NUM_PADS);

  logic                start;
  logic                busy;
  logic                done;
  logic [AW-1:0]       cfg_addr;
  logic [CFG_BITS-1:0] cfg_data;
  logic                serial_clock;
  logic                serial_load;
  logic                serial_data_1;
  logic                serial_data_2;

  modport master (
    input  start, cfg_data,
    output busy, done, cfg_addr,
    output serial_clock, serial_load, serial_data_1, serial_data_2
  );

  modport slave (
    output start, cfg_data,
    input  busy, done, cfg_addr,
    input  serial_clock, serial_load, serial_data_1, serial_data_2
  );
endinterface

// File: rtl/gpio_serial_cfg_loader.sv
// Shifts per-pad config words into two daisy-chained GPIO control chains, then strobes load.
// Optional CFG_LOADER_BITBANG_EN adds bb_* inputs that drive the serial pins directly while idle.
module gpio_serial_cfg_loader #(
  parameter int NUM_PADS = 38,
  parameter int CFG_BITS = 13,
  parameter int CLK_DIV  = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  gpio_serial_cfg_loader_if.master        bus,
  output logic [2:0]                      dbg_state
`ifdef CFG_LOADER_BITBANG_EN
  ,
  input  logic                            bb_enable,
  input  logic                            bb_clock,
  input  logic                            bb_load,
  input  logic                            bb_data_1,
  input  logic                            bb_data_2
`endif
);
  localparam int HALF = NUM_PADS / 2;
  localparam int AW   = $clog2(NUM_PADS);
  localparam int KW   = $clog2(HALF + 1);
  localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW   = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam int MSB  = CFG_BITS - 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(CFG_BITS - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_A, S_FETCH_B, S_SHIFT, S_LOAD, S_DONE
  } state_t;

  state_t              state;
  logic                busy_q, done_q, sclk_q, load_q, sd1_q, sd2_q;
  logic [AW-1:0]       addr_q;
  logic [CFG_BITS-1:0] shift_1, shift_2;
  logic [KW-1:0]       k;
  logic [DW-1:0]       div_cnt;
  logic [BW-1:0]       bit_cnt;
  logic                phase_hi;
  logic                second;
  logic                start_ok;

  // Handshake: start is a one-cycle request honoured only in IDLE (never queued);
  // busy is high from the cycle after acceptance through the done pulse.
`ifdef CFG_LOADER_BITBANG_EN
  logic bb_mode;
  assign bb_mode           = bb_enable && (state == S_IDLE);
  assign start_ok          = bus.start && !bb_enable;
  assign bus.serial_clock  = bb_mode ? bb_clock  : sclk_q;
  assign bus.serial_load   = bb_mode ? bb_load   : load_q;
  assign bus.serial_data_1 = bb_mode ? bb_data_1 : sd1_q;
  assign bus.serial_data_2 = bb_mode ? bb_data_2 : sd2_q;
`else
  assign start_ok          = bus.start;
  assign bus.serial_clock  = sclk_q;
  assign bus.serial_load   = load_q;
  assign bus.serial_data_1 = sd1_q;
  assign bus.serial_data_2 = sd2_q;
`endif

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.cfg_addr = addr_q;
  assign dbg_state    = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sclk_q   <= 1'b0;
      load_q   <= 1'b0;
      sd1_q    <= 1'b0;
      sd2_q    <= 1'b0;
      addr_q   <= '0;
      shift_1  <= '0;
      shift_2  <= '0;
      k        <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      phase_hi <= 1'b0;
      second   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            state  <= S_FETCH_A;
            busy_q <= 1'b1;
            k      <= '0;
            addr_q <= '0;
            second <= 1'b0;
          end
        end
        S_FETCH_A: begin
          if (!second) begin
            second <= 1'b1;
          end else begin
            second  <= 1'b0;
            shift_1 <= bus.cfg_data;
            addr_q  <= AW'(NUM_PADS - 1) - AW'(k);
            state   <= S_FETCH_B;
          end
        end
        S_FETCH_B: begin
          if (!second) begin
            second <= 1'b1;
          end else begin
            // Present the first bit of both words now: this is the first low cycle.
            second   <= 1'b0;
            sd1_q    <= shift_1[MSB];
            sd2_q    <= bus.cfg_data[MSB];
            shift_1  <= shift_1 << 1;
            shift_2  <= bus.cfg_data << 1;
            sclk_q   <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            phase_hi <= 1'b0;
            state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!phase_hi) begin
              phase_hi <= 1'b1;
              sclk_q   <= 1'b1;
            end else begin
              phase_hi <= 1'b0;
              sclk_q   <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                sd1_q <= 1'b0;
                sd2_q <= 1'b0;
                k     <= k + 1'b1;
                if (k == K_LAST) begin
                  load_q <= 1'b1;
                  state  <= S_LOAD;
                end else begin
                  addr_q <= AW'(k) + AW'(1);
                  state  <= S_FETCH_A;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                sd1_q   <= shift_1[MSB];
                sd2_q   <= shift_2[MSB];
                shift_1 <= shift_1 << 1;
                shift_2 <= shift_2 << 1;
              end
            end
          end
        end
        S_LOAD: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            load_q  <= 1'b0;
            done_q  <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gpio_serial_cfg_loader.sv
// Bench for gpio_serial_cfg_loader: default instance (38 pads, 13 bits, div 2) and a
// small instance (4 pads, 3 bits, div 1), each observed through a behavioural chain model.
module tb_gpio_serial_cfg_loader;
  localparam int NA = 38, CA = 13, DA = 2, HA = NA / 2;
  localparam int NB = 4,  CB = 3,  DB = 1, HB = NB / 2;
  localparam int TA = HA * (4 + 2 * DA * CA) + DA + 1;
  localparam int TB = HB * (4 + 2 * DB * CB) + DB + 1;

  logic clock = 0;
  logic reset = 1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  gpio_serial_cfg_loader_if #(.NUM_PADS(NA), .CFG_BITS(CA)) bus_a ();
  gpio_serial_cfg_loader_if #(.NUM_PADS(NB), .CFG_BITS(CB)) bus_b ();
  logic [2:0] dbg_a, dbg_b;

`ifdef CFG_LOADER_BITBANG_EN
  logic bb_enable = 0, bb_clock = 0, bb_load = 0, bb_data_1 = 0, bb_data_2 = 0;
  logic bb_zero = 0;
`endif

  gpio_serial_cfg_loader #(.NUM_PADS(NA), .CFG_BITS(CA), .CLK_DIV(DA)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a), .dbg_state(dbg_a)
`ifdef CFG_LOADER_BITBANG_EN
    , .bb_enable(bb_enable), .bb_clock(bb_clock), .bb_load(bb_load),
    .bb_data_1(bb_data_1), .bb_data_2(bb_data_2)
`endif
  );

  gpio_serial_cfg_loader #(.NUM_PADS(NB), .CFG_BITS(CB), .CLK_DIV(DB)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b), .dbg_state(dbg_b)
`ifdef CFG_LOADER_BITBANG_EN
    , .bb_enable(bb_zero), .bb_clock(bb_zero), .bb_load(bb_zero),
    .bb_data_1(bb_zero), .bb_data_2(bb_zero)
`endif
  );

  // Config register files: synchronous read, data one cycle after address.
  logic [CA-1:0] mem_a [NA];
  logic [CB-1:0] mem_b [NB];
  always @(posedge clock) bus_a.cfg_data <= mem_a[bus_a.cfg_addr];
  always @(posedge clock) bus_b.cfg_data <= mem_b[bus_b.cfg_addr];

  // Chain models: every rising serial_clock pushes one bit into each chain;
  // the first word shifted ends up in the farthest pad when load fires.
  bit s1_a[$], s2_a[$], s1_b[$], s2_b[$];
  int rise_b[$];
  int loads_a = 0, load_cyc_a = 0, dones_a = 0, loads_b = 0;
  bit psc_a = 0, pld_a = 0, pdn_a = 0, psc_b = 0, pld_b = 0;
  logic [CA-1:0] pads_a [NA];
  logic [CB-1:0] pads_b [NB];

  task automatic latch_a();
    int n, base;
    logic [CA-1:0] w1, w2;
    n = HA * CA;
    if (s1_a.size() < n || s2_a.size() < n) return;
    base = s1_a.size() - n;
    for (int j = 0; j < HA; j++) begin
      w1 = '0; w2 = '0;
      for (int b = 0; b < CA; b++) begin
        w1 = {w1[CA-2:0], s1_a[base + j*CA + b]};
        w2 = {w2[CA-2:0], s2_a[base + j*CA + b]};
      end
      pads_a[j] = w1;
      pads_a[NA-1-j] = w2;
    end
  endtask

  task automatic latch_b();
    int n, base;
    logic [CB-1:0] w1, w2;
    n = HB * CB;
    if (s1_b.size() < n || s2_b.size() < n) return;
    base = s1_b.size() - n;
    for (int j = 0; j < HB; j++) begin
      w1 = '0; w2 = '0;
      for (int b = 0; b < CB; b++) begin
        w1 = {w1[CB-2:0], s1_b[base + j*CB + b]};
        w2 = {w2[CB-2:0], s2_b[base + j*CB + b]};
      end
      pads_b[j] = w1;
      pads_b[NB-1-j] = w2;
    end
  endtask

  always @(negedge clock) begin
    if (bus_a.serial_clock === 1'b1 && !psc_a) begin
      s1_a.push_back(bus_a.serial_data_1);
      s2_a.push_back(bus_a.serial_data_2);
    end
    if (bus_a.serial_load === 1'b1) load_cyc_a++;
    if (bus_a.serial_load === 1'b1 && !pld_a) begin
      loads_a++;
      latch_a();
    end
    if (bus_a.done === 1'b1 && !pdn_a) dones_a++;
    psc_a = (bus_a.serial_clock === 1'b1);
    pld_a = (bus_a.serial_load === 1'b1);
    pdn_a = (bus_a.done === 1'b1);
  end

  always @(negedge clock) begin
    if (bus_b.serial_clock === 1'b1 && !psc_b) begin
      s1_b.push_back(bus_b.serial_data_1);
      s2_b.push_back(bus_b.serial_data_2);
      rise_b.push_back(cyc);
    end
    if (bus_b.serial_load === 1'b1 && !pld_b) begin
      loads_b++;
      latch_b();
    end
    psc_b = (bus_b.serial_clock === 1'b1);
    pld_b = (bus_b.serial_load === 1'b1);
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_a();
    s1_a.delete(); s2_a.delete();
    loads_a = 0; load_cyc_a = 0; dones_a = 0;
    for (int i = 0; i < NA; i++) pads_a[i] = 'x;
  endtask

  task automatic run_a(input bit hold, output int lat);
    @(negedge clock);
    bus_a.start = 1'b1;
    @(negedge clock);
    if (!hold) bus_a.start = 1'b0;
    chk("a_busy_after_start", {31'd0, bus_a.busy}, 32'd1);
    lat = 1;
    while (bus_a.done !== 1'b1 && lat < 5000) begin
      @(negedge clock);
      lat++;
    end
    bus_a.start = 1'b0;
    chk("a_done_seen", {31'd0, bus_a.done}, 32'd1);
    chk("a_busy_with_done", {31'd0, bus_a.busy}, 32'd1);
    @(negedge clock);
    chk("a_done_one_cycle", {31'd0, bus_a.done}, 32'd0);
    chk("a_busy_falls", {31'd0, bus_a.busy}, 32'd0);
  endtask

  task automatic check_pads_a(input string tag);
    for (int i = 0; i < NA; i++)
      chk($sformatf("%s_pad%0d", tag, i), {19'd0, pads_a[i]}, {19'd0, mem_a[i]});
  endtask

  task automatic full_load_a(input string tag);
    int lat;
    for (int i = 0; i < NA; i++) mem_a[i] = CA'(i * 'h111);
    clear_a();
    run_a(1'b0, lat);
    chk({tag, "_latency"}, lat, TA);
    chk({tag, "_edges1"}, s1_a.size(), HA * CA);
    chk({tag, "_edges2"}, s2_a.size(), HA * CA);
    chk({tag, "_loads"}, loads_a, 1);
    chk({tag, "_load_cycles"}, load_cyc_a, DA);
    check_pads_a(tag);
  endtask

  initial begin
    int lat;
    logic [CA-1:0] w;
    bus_a.start = 0;
    bus_b.start = 0;
    for (int i = 0; i < NA; i++) mem_a[i] = '0;
    for (int i = 0; i < NB; i++) mem_b[i] = '0;

    // Reset values
    repeat (3) @(negedge clock);
    chk("rst_busy", {31'd0, bus_a.busy}, 0);
    chk("rst_done", {31'd0, bus_a.done}, 0);
    chk("rst_sclk", {31'd0, bus_a.serial_clock}, 0);
    chk("rst_load", {31'd0, bus_a.serial_load}, 0);
    chk("rst_sd1", {31'd0, bus_a.serial_data_1}, 0);
    chk("rst_sd2", {31'd0, bus_a.serial_data_2}, 0);
    chk("rst_addr", {26'd0, bus_a.cfg_addr}, 0);
    reset = 0;
    repeat (2) @(negedge clock);

    // Reset in the middle of shifting
    for (int i = 0; i < NA; i++) mem_a[i] = CA'($urandom);
    clear_a();
    bus_a.start = 1;
    @(negedge clock);
    bus_a.start = 0;
    repeat (100) @(negedge clock);
    chk("mid_busy", {31'd0, bus_a.busy}, 1);
    chk("mid_shifting", {31'd0, s1_a.size() > 0}, 1);
    reset = 1;
    #1;
    chk("mid_rst_busy", {31'd0, bus_a.busy}, 0);
    chk("mid_rst_sclk", {31'd0, bus_a.serial_clock}, 0);
    chk("mid_rst_sd1", {31'd0, bus_a.serial_data_1}, 0);
    chk("mid_rst_sd2", {31'd0, bus_a.serial_data_2}, 0);
    chk("mid_rst_load", {31'd0, bus_a.serial_load}, 0);
    chk("mid_rst_addr", {26'd0, bus_a.cfg_addr}, 0);
    repeat (3) @(negedge clock);
    reset = 0;
    repeat (20) @(negedge clock);
    chk("mid_rst_no_load", loads_a, 0);
    chk("mid_rst_no_done", dones_a, 0);

    // Full load with i*0x111 pattern
    full_load_a("full");

    // Order: only pad 0 set
    for (int i = 0; i < NA; i++) mem_a[i] = '0;
    mem_a[0] = 13'h1FFF;
    clear_a();
    run_a(1'b0, lat);
    w = '0;
    for (int b = 0; b < CA; b++) w = {w[CA-2:0], s1_a[b]};
    chk("order_first_word1", {19'd0, w}, 32'h1FFF);
    w = '0;
    for (int b = 0; b < CA; b++) w = {w[CA-2:0], s2_a[b]};
    chk("order_first_word2", {19'd0, w}, 0);
    check_pads_a("order");

    // start held high for the whole sequence
    for (int i = 0; i < NA; i++) mem_a[i] = CA'($urandom);
    clear_a();
    run_a(1'b1, lat);
    repeat (50) @(negedge clock);
    chk("hold_latency", lat, TA);
    chk("hold_one_done", dones_a, 1);
    chk("hold_one_load", loads_a, 1);
    chk("hold_idle_after", {31'd0, bus_a.busy}, 0);
    check_pads_a("hold");

    // Random words, random idle gaps
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NA; i++) mem_a[i] = CA'($urandom);
      clear_a();
      repeat ($urandom_range(1, 7)) @(negedge clock);
      run_a(1'b0, lat);
      chk($sformatf("rand%0d_latency", r), lat, TA);
      chk($sformatf("rand%0d_loads", r), loads_a, 1);
      check_pads_a($sformatf("rand%0d", r));
    end

    // Small configuration: 4 pads, 3 bits, CLK_DIV=1
    for (int i = 0; i < NB; i++) mem_b[i] = CB'($urandom);
    s1_b.delete(); s2_b.delete(); rise_b.delete(); loads_b = 0;
    @(negedge clock);
    bus_b.start = 1;
    @(negedge clock);
    bus_b.start = 0;
    lat = 1;
    while (bus_b.done !== 1'b1 && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    chk("small_latency", lat, TB);
    chk("small_edges", s1_b.size(), HB * CB);
    chk("small_period", (rise_b.size() > 1) ? rise_b[1] - rise_b[0] : -1, 2 * DB);
    chk("small_loads", loads_b, 1);
    for (int i = 0; i < NB; i++)
      chk($sformatf("small_pad%0d", i), {29'd0, pads_b[i]}, {29'd0, mem_b[i]});
    @(negedge clock);

`ifdef CFG_LOADER_BITBANG_EN
    // Bit-bang mirror while idle; start ignored while enabled
    bb_enable = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      bb_clock  = 1'($urandom);
      bb_data_1 = 1'($urandom);
      bb_data_2 = 1'($urandom);
      bb_load   = 1'($urandom);
      #1;
      chk("bb_sclk", {31'd0, bus_a.serial_clock}, {31'd0, bb_clock});
      chk("bb_sd1", {31'd0, bus_a.serial_data_1}, {31'd0, bb_data_1});
      chk("bb_sd2", {31'd0, bus_a.serial_data_2}, {31'd0, bb_data_2});
      chk("bb_load", {31'd0, bus_a.serial_load}, {31'd0, bb_load});
    end
    @(negedge clock);
    bus_a.start = 1;
    @(negedge clock);
    bus_a.start = 0;
    repeat (3) @(negedge clock);
    chk("bb_start_ignored", {31'd0, bus_a.busy}, 0);
    bb_enable = 0; bb_clock = 0; bb_data_1 = 0; bb_data_2 = 0; bb_load = 0;
    repeat (2) @(negedge clock);
    full_load_a("bb_off");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
